// File: rtl/s_load_buf_if.sv
// s_load_buf_if: sample stream in, parallel 8-slot frame out, for the FFT input loader.
interface s_load_buf_if #(parameter int DW = 32);
    logic          in_valid;
    logic          in_ready;
    logic          in_sof;
    logic [2*DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic          frame_err;
    logic [DW-1:0] data00_r, data01_r, data02_r, data03_r, data04_r, data05_r, data06_r, data07_r;
    logic [DW-1:0] data00_i, data01_i, data02_i, data03_i, data04_i, data05_i, data06_i, data07_i;
    modport slave (
        input  in_valid, in_sof, in_data, out_ready,
        output in_ready, out_valid, frame_err,
        output data00_r, data01_r, data02_r, data03_r, data04_r, data05_r, data06_r, data07_r,
        output data00_i, data01_i, data02_i, data03_i, data04_i, data05_i, data06_i, data07_i
    );
    modport master (
        output in_valid, in_sof, in_data, out_ready,
        input  in_ready, out_valid, frame_err,
        input  data00_r, data01_r, data02_r, data03_r, data04_r, data05_r, data06_r, data07_r,
        input  data00_i, data01_i, data02_i, data03_i, data04_i, data05_i, data06_i, data07_i
    );
endinterface

// File: rtl/s_load_buf.sv
// s_load_buf: collects a serial complex sample stream into 8-point frames and
// presents each frame as eight parallel re/im words under a valid/ready handshake.
module s_load_buf #(
    parameter int DW      = 32,
    parameter int BIT_REV = 0
) (
    input logic         clk,
    input logic         rst_n,
    s_load_buf_if.slave bus
);
    typedef enum logic {FILL, HOLD} state_t;
    state_t          state, state_nxt;
    logic [2:0]      cnt, k, s;
    logic [2*DW-1:0] col [8];
    logic [2*DW-1:0] nxt [8];
    logic [DW-1:0]   out_r [8];
    logic [DW-1:0]   out_i [8];
    logic            out_valid, frame_err, acc, slot_free, done, load_direct, load;
    assign bus.in_ready = state == FILL;
    assign acc         = bus.in_valid && state == FILL;
    assign k           = bus.in_sof ? 3'd0 : cnt;
    assign s           = BIT_REV != 0 ? {k[0], k[1], k[2]} : k;
    assign slot_free   = !out_valid || bus.out_ready;
    assign done        = acc && !bus.in_sof && cnt == 3'd7;
    assign load_direct = done && slot_free;
    // HOLD always has a frame showing, so out_ready alone means the old one leaves
    assign load        = load_direct || (state == HOLD && bus.out_ready);
    always_comb begin
        state_nxt = state;
        state_nxt = state == FILL ? (done && !slot_free ? HOLD : FILL) : (bus.out_ready ? FILL : HOLD);
        for (int i = 0; i < 8; i++)
            nxt[i] = load_direct && 3'(i) == s ? bus.in_data : col[i];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                col[i]   <= '0;
                out_r[i] <= '0;
                out_i[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            frame_err <= acc && bus.in_sof && cnt != 3'd0;
            if (acc) begin
                col[s] <= bus.in_data;
                cnt    <= bus.in_sof ? 3'd1 : cnt + 3'd1;
            end
            if (load)
                out_valid <= 1'b1;
            else if (bus.out_ready)
                out_valid <= 1'b0;
            if (load)
                for (int i = 0; i < 8; i++) begin
                    out_r[i] <= nxt[i][2*DW-1:DW];
                    out_i[i] <= nxt[i][DW-1:0];
                end
        end
    end
    assign bus.out_valid = out_valid;
    assign bus.frame_err = frame_err;
    assign bus.data00_r = out_r[0];
    assign bus.data01_r = out_r[1];
    assign bus.data02_r = out_r[2];
    assign bus.data03_r = out_r[3];
    assign bus.data04_r = out_r[4];
    assign bus.data05_r = out_r[5];
    assign bus.data06_r = out_r[6];
    assign bus.data07_r = out_r[7];
    assign bus.data00_i = out_i[0];
    assign bus.data01_i = out_i[1];
    assign bus.data02_i = out_i[2];
    assign bus.data03_i = out_i[3];
    assign bus.data04_i = out_i[4];
    assign bus.data05_i = out_i[5];
    assign bus.data06_i = out_i[6];
    assign bus.data07_i = out_i[7];
endmodule

// File: doc/s_load_buf.md
Name: s_load_buf

Overview:
- Serial-to-parallel frame loader at the FFT input. It is the write-side counterpart of the parallel-capture / serial-readout sample register file.
- Accepts a stream of packed complex samples over a valid/ready handshake and collects them into 8-point frames.
- Presents each completed frame as eight parallel real/imag words to the butterfly stage, held under a valid/ready handshake.
- Optional bit-reversed slot placement feeds a decimation-in-time datapath directly.

Parameters:
DW, 32, width of each real and each imaginary component
BIT_REV, 0, 0 = sample k lands in slot k; 1 = sample k lands in slot bitrev3(k)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream sample valid
in_ready  out  1  loader can accept a sample this cycle
in_sof  in  1  qualifies in_data as sample 0 of a frame
in_data  in  2*DW  packed sample {re, im}; re in the upper DW bits
out_valid  out  1  parallel frame valid
out_ready  in  1  downstream consumes frame this cycle
data00_r..data07_r  out  DW each  real part, slots 0..7
data00_i..data07_i  out  DW each  imag part, slots 0..7
frame_err  out  1  one-cycle pulse: partial frame discarded

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=FILL, cnt=0, out_valid=0.
  - All dataNN_r/_i=0, collector=0, frame_err=0.
  - in_ready=1 once state=FILL, including while in reset.
- Accept: in_valid && in_ready at a rising edge.
- Output slot free: !out_valid || out_ready.
- Slot index: s = BIT_REV ? bitrev3(k) : k, where k is the sample index within the frame (cnt, or 0 when in_sof).
- State FILL, in_ready=1:
  - Accept with in_sof=1: sample is index 0; collector[s(0)] <= in_data; cnt <= 1. If cnt != 0 at that edge, the partial frame is dropped and frame_err pulses 1 for the next cycle.
  - Accept with in_sof=0 and cnt<7: collector[s(cnt)] <= in_data; cnt <= cnt+1. in_sof is never required; frames are counted from reset or the last sof.
  - Accept with in_sof=0 and cnt==7 (frame complete):
    - Output slot free: output regs load collector slots plus in_data into slot s(7) on the same edge, giving zero bubble. out_valid <= 1, cnt <= 0, remain in FILL.
    - Output slot not free: collector[s(7)] <= in_data, cnt <= 0, go to HOLD.
  - No accept: collector and cnt hold.
- State HOLD, in_ready=0:
  - out_valid is 1 here by construction.
  - On out_ready: output regs load the collector, out_valid stays 1, go to FILL.
  - in_sof/in_valid are ignored; nothing is accepted.
- Output handshake:
  - out_valid && out_ready with no new load on that edge: out_valid <= 0.
  - Data outputs hold their last value (no clearing) while out_valid=0.
  - Data outputs are stable while out_valid && !out_ready.
- Latency: the frame is visible one edge after its 8th sample is accepted when the slot is free. Sustained throughput is 1 sample/cycle with out_ready tied high.
- Pure register transfer: no arithmetic or width conversion. Upper DW bits go to _r, lower DW bits to _i.
- Reset asserted mid-frame or mid-HOLD: everything returns to reset values immediately. The partial frame is lost and frame_err is not raised.
- All outputs except in_ready are registered. in_ready is decoded from state only, with no combinational path from out_ready.

Test Plan:
- Reset, then 8 accepts of {re=k+1, im=0x100+k} with k=0..7 and sof on k=0, out_ready=1, BIT_REV=0 -> out_valid=1 one edge after the 8th accept; data03_r=4, data03_i=0x103; no frame_err.
- Same stimulus with BIT_REV=1 -> data04_r=2 (sample 1), data01_r=5 (sample 4), data07_r=8, data00_r=1.
- out_ready=0; stream 16 samples continuously -> frame 1 shown; in_ready drops the cycle after the 16th accept (HOLD). Raise out_ready -> frame 2 appears next edge, in_ready returns to 1.
- 3 samples, then in_sof on a new sample A, then 7 more -> frame_err pulses exactly 1 cycle; resulting frame has slot0=A; the 3 stale samples are absent.
- Back-to-back 4 frames, in_valid=1 and out_ready=1 throughout -> in_ready never drops; out_valid=1 on every 8th edge, frames contiguous.
- Assert rst_n low during HOLD with out_valid=1 -> out_valid, all data outputs, and frame_err read 0 immediately; next sample after release is treated as index 0.
